// File: rtl/pipeline_defs.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_defs (package)
//  Purpose  : Encodings shared by the MIPS32 pipeline stages. Used here for
//             write-back source select and the hardwired zero register, and
//             by the ID/EX control and forwarding logic.
//  Contents : mtr_sel_e   - MemtoReg write-back source encoding
//             REG_ZERO    - architectural $0 address
//  Revision : 1.0 - initial release
// ============================================================================
package pipeline_defs;

    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_PC4 = 2'b10,
        MTR_RSV = 2'b11   // reserved; treated as ALU result
    } mtr_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/wb_regfile_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile_reg_file
//  Purpose  : 2^NREG_LOG2 x DATA_W architectural register file. One write
//             port, two combinational read ports with same-cycle write-through
//             bypass, register 0 reads as zero.
//  Ports    : clk, rst (async, active-high)
//             wr_en, wr_addr, wr_data     - commit port
//             rd_addr1/2 -> rd_data1/2    - decode read ports
//  Revision : 1.0 - initial release
// ============================================================================
module wb_regfile_reg_file
    import pipeline_defs::*;
#(
    parameter int DATA_W    = 32,
    parameter int NREG_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [NREG_LOG2-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [NREG_LOG2-1:0] rd_addr1,
    input  logic [NREG_LOG2-1:0] rd_addr2,
    output logic [DATA_W-1:0]    rd_data1,
    output logic [DATA_W-1:0]    rd_data2
);

    localparam int NREG = 1 << NREG_LOG2;
    localparam logic [NREG_LOG2-1:0] ZERO_ADDR = NREG_LOG2'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREG];

    // Guard on address as well so the storage is self-protecting even if a
    // caller ever drives a write strobe at $0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // $0 check takes priority over bypass so a stray write to $0 can never
    // leak through the read port.
    always_comb begin
        rd_data1 = regs[rd_addr1];
        if (rd_addr1 == ZERO_ADDR) begin
            rd_data1 = '0;
        end else if (wr_en && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
    end

    always_comb begin
        rd_data2 = regs[rd_addr2];
        if (rd_addr2 == ZERO_ADDR) begin
            rd_data2 = '0;
        end else if (wr_en && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : MIPS32 write-back stage plus architectural register file.
//             Selects the write-back value, commits it, serves two bypassed
//             decode read ports and counts retired register writes.
//  Ports    : clk, rst (async, active-high)
//             MEM_WB_*        - MEM/WB pipeline register outputs
//             RdAddr1/2       - decode read addresses (rs, rt)
//             RdData1/2       - decode read data
//             WB_WrData       - selected write-back value (also to EX fwd mux)
//             WB_WrEn         - effective write strobe (never for $0)
//             RetireCnt       - committed writes since reset, wraps at 2^32
//  Revision : 1.0 - initial release
// ============================================================================
module wb_regfile
    import pipeline_defs::*;
#(
    parameter int DATA_W    = 32,
    parameter int NREG_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    MEM_WB_MemRdData,
    input  logic [DATA_W-1:0]    MEM_WB_ALUOut,
    input  logic [DATA_W-1:0]    MEM_WB_PC4,
    input  logic [NREG_LOG2-1:0] MEM_WB_RegWrAddr,
    input  logic [1:0]           MEM_WB_MemtoReg,
    input  logic                 MEM_WB_RegWr,
    input  logic [NREG_LOG2-1:0] RdAddr1,
    input  logic [NREG_LOG2-1:0] RdAddr2,
    output logic [DATA_W-1:0]    RdData1,
    output logic [DATA_W-1:0]    RdData2,
    output logic [DATA_W-1:0]    WB_WrData,
    output logic                 WB_WrEn,
    output logic [31:0]          RetireCnt
);

    logic [DATA_W-1:0] wb_data;
    logic              wb_en;
    logic [31:0]       retire_cnt;

    always_comb begin
        wb_data = MEM_WB_ALUOut;
        case (mtr_sel_e'(MEM_WB_MemtoReg))
            MTR_MEM: wb_data = MEM_WB_MemRdData;
            MTR_PC4: wb_data = MEM_WB_PC4;
            default: wb_data = MEM_WB_ALUOut;
        endcase
    end

    assign wb_en = MEM_WB_RegWr && (MEM_WB_RegWrAddr != NREG_LOG2'(REG_ZERO));

    // Free-running retire counter; natural modulo-2^32 wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (wb_en) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    wb_regfile_reg_file #(
        .DATA_W    (DATA_W),
        .NREG_LOG2 (NREG_LOG2)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wb_en),
        .wr_addr  (MEM_WB_RegWrAddr),
        .wr_data  (wb_data),
        .rd_addr1 (RdAddr1),
        .rd_addr2 (RdAddr2),
        .rd_data1 (RdData1),
        .rd_data2 (RdData2)
    );

    assign WB_WrData = wb_data;
    assign WB_WrEn   = wb_en;
    assign RetireCnt = retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Self-checking bench for wb_regfile. Directed scenarios followed
//             by random traffic, all compared against a register-array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_rd_data, alu_out, pc4;
    logic [4:0]  wr_addr;
    logic [1:0]  mem_to_reg;
    logic        reg_wr;
    logic [4:0]  rd_addr1, rd_addr2;
    wire  [31:0] rd_data1, rd_data2, wb_wr_data, retire_cnt;
    wire         wb_wr_en;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(32), .NREG_LOG2(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .MEM_WB_MemRdData (mem_rd_data),
        .MEM_WB_ALUOut    (alu_out),
        .MEM_WB_PC4       (pc4),
        .MEM_WB_RegWrAddr (wr_addr),
        .MEM_WB_MemtoReg  (mem_to_reg),
        .MEM_WB_RegWr     (reg_wr),
        .RdAddr1          (rd_addr1),
        .RdAddr2          (rd_addr2),
        .RdData1          (rd_data1),
        .RdData2          (rd_data2),
        .WB_WrData        (wb_wr_data),
        .WB_WrEn          (wb_wr_en),
        .RetireCnt        (retire_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_wb_val();
        case (mem_to_reg)
            2'b01:   return mem_rd_data;
            2'b10:   return pc4;
            default: return alu_out;
        endcase
    endfunction

    function automatic logic m_wen();
        return reg_wr && (wr_addr != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0)                   return 32'd0;
        if (m_wen() && a == wr_addr)     return m_wb_val();
        return m_regs[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
    endtask

    // One WB cycle, entered just after a falling edge: apply inputs, check
    // combinational outputs, take the rising edge, update model, check counter.
    task automatic step(input logic wr, input logic [4:0] wa, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] p4,
                        input logic [4:0] r1, input logic [4:0] r2, input string tag);
        reg_wr = wr; wr_addr = wa; mem_to_reg = sel;
        alu_out = alu; mem_rd_data = mem; pc4 = p4;
        rd_addr1 = r1; rd_addr2 = r2;
        #1;
        check({tag, ".wdata"}, wb_wr_data, m_wb_val());
        check({tag, ".wen"},   {31'd0, wb_wr_en}, {31'd0, m_wen()});
        check({tag, ".rd1"},   rd_data1, m_read(r1));
        check({tag, ".rd2"},   rd_data2, m_read(r2));
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else if (m_wen()) begin
            m_regs[wr_addr] = m_wb_val();
            m_cnt = m_cnt + 32'd1;
        end
        #1;
        check({tag, ".cnt"}, retire_cnt, m_cnt);
        @(negedge clk);
    endtask

    task automatic idle_read(input logic [4:0] r1, input logic [4:0] r2, input string tag);
        step(1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0, r1, r2, tag);
    endtask

    initial begin
        m_reset();
        rst = 1'b1;
        reg_wr = 1'b0; wr_addr = '0; mem_to_reg = '0;
        alu_out = '0; mem_rd_data = '0; pc4 = '0;
        rd_addr1 = 5'd5; rd_addr2 = 5'd0;
        #1;
        check("reset.rd1", rd_data1, 32'd0);
        check("reset.cnt", retire_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset clears state, asynchronously
        step(1'b1, 5'd5, 2'b00, 32'hDEADBEEF, 32'd0, 32'd0, 5'd5, 5'd5, "wr5");
        idle_read(5'd5, 5'd0, "rd5");
        check("rd5.literal", rd_data1, 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        check("async_rst.rd1", rd_data1, 32'd0);
        check("async_rst.cnt", retire_cnt, 32'd0);
        m_reset();
        @(negedge clk);
        // Write attempt while reset held must not commit or count
        step(1'b1, 5'd6, 2'b00, 32'h12345678, 32'd0, 32'd0, 5'd7, 5'd7, "in_rst");
        rst = 1'b0;
        idle_read(5'd6, 5'd5, "post_rst");
        check("post_rst.r6", rd_data1, 32'd0);

        // Source select, each writing $8 then read back from storage
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 5'd8, 2'(s), 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, "srcsel.wr");
            idle_read(5'd8, 5'd8, "srcsel.rd");
            check("srcsel.literal", rd_data1, (s == 1) ? 32'h22 : (s == 2) ? 32'h33 : 32'h11);
        end

        // Bypass on both ports, then same values from storage
        step(1'b1, 5'd9, 2'b00, 32'hCAFE0001, 32'd0, 32'd0, 5'd9, 5'd9, "bypass");
        idle_read(5'd9, 5'd9, "bypass.after");
        check("bypass.literal", rd_data2, 32'hCAFE0001);

        // $0 protection
        step(1'b1, 5'd0, 2'b00, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd0, 5'd0, "zero_wr");
        check("zero.literal", rd_data1, 32'd0);

        // Counter: fresh reset, then 10 writes interleaved with 5 idle cycles
        rst = 1'b1; #1; m_reset(); @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i % 3 == 2)
                idle_read(5'(i), 5'(i + 1), "cnt.idle");
            else
                step(1'b1, 5'(i % 31 + 1), 2'b00, 32'(i), 32'd0, 32'd0, 5'(i), 5'(i + 1), "cnt.wr");
        end
        check("cnt.ten", retire_cnt, 32'd10);

        // Counter wrap via hierarchical deposit
        dut.retire_cnt = 32'hFFFFFFFF;
        m_cnt = 32'hFFFFFFFF;
        step(1'b1, 5'd4, 2'b00, 32'h4, 32'd0, 32'd0, 5'd4, 5'd0, "wrap");
        check("wrap.literal", retire_cnt, 32'd0);

        // Back-to-back writes to $3
        for (int v = 1; v <= 3; v++) begin
            reg_wr = 1'b1; wr_addr = 5'd3; mem_to_reg = 2'b00; alu_out = 32'(v);
            rd_addr1 = 5'd3;
            #1;
            check("b2b.literal", rd_data1, 32'(v));
            step(1'b1, 5'd3, 2'b00, 32'(v), 32'd0, 32'd0, 5'd3, 5'd3, "b2b");
        end

        // Random traffic, addresses biased toward collisions
        for (int i = 0; i < 300; i++) begin
            logic [4:0] wa, a1, a2;
            wa = 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            step(1'($urandom), wa, 2'($urandom), $urandom, $urandom, $urandom, a1, a2, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
